// File: rtl/sl_spi_slave.sv
// SPI mode-0 (CPOL=0, CPHA=0, MSB first) slave, oversampled in the clk domain.
// Exchanges words with local logic via a TX holding register and an RX valid/ready port.
//
// state  | meaning
// IDLE   | not selected, MISO tri-stated, SCLK edges ignored
// ACTIVE | selected, shifting on SCLK edges
module sl_spi_slave #(
  parameter int                DATA_W      = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_BYTE   = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_ss_i,
  input  logic              spi_sclk_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_en,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_val,
  output logic              tx_rdy,
  output logic              tx_undr,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_val,
  input  logic              rx_rdy,
  output logic              rx_ovf,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state;
  logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
  logic              ss_d, sclk_d;
  logic              ss_s, sclk_s, mosi_s;
  logic              ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_shift, rx_shift, rx_next;
  logic [DATA_W-1:0] hold_data;
  logic              hold_full;
  logic              word_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_d      <= 1'b1;
      sclk_d    <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_i};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      ss_d      <= ss_s;
      sclk_d    <= sclk_s;
    end
  end

  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ss_fall   = ss_d & ~ss_s;
  assign ss_rise   = ~ss_d & ss_s;
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign rx_next   = {rx_shift[DATA_W-2:0], mosi_s};

  // A load happens at selection and on the first falling edge after a full word;
  // a deselect in the same cycle takes priority over any SCLK edge.
  always_comb begin
    word_load = 1'b0;
    if (state == IDLE)
      word_load = ss_fall;
    else if (!ss_rise && sclk_fall && bit_cnt == '0)
      word_load = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      spi_miso_en <= 1'b0;
      bit_cnt     <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_val      <= 1'b0;
      rx_ovf      <= 1'b0;
      tx_undr     <= 1'b0;
      hold_data   <= '0;
      hold_full   <= 1'b0;
    end else begin
      tx_undr <= 1'b0;
      rx_ovf  <= 1'b0;

      if (rx_val && rx_rdy)
        rx_val <= 1'b0;

      // The load sees the holding register as it was before this cycle's write.
      if (word_load) begin
        if (hold_full)
          tx_shift <= hold_data;
        else begin
          tx_shift <= IDLE_BYTE;
          tx_undr  <= 1'b1;
        end
      end

      if (word_load && hold_full)
        hold_full <= 1'b0;
      else if (tx_val && !hold_full) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (ss_fall) begin
            state       <= ACTIVE;
            busy        <= 1'b1;
            spi_miso_en <= 1'b1;
            bit_cnt     <= '0;
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state       <= IDLE;
            busy        <= 1'b0;
            spi_miso_en <= 1'b0;
            bit_cnt     <= '0;
            rx_shift    <= '0;
          end else if (sclk_rise) begin
            rx_shift <= rx_next;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              rx_data <= rx_next;
              rx_val  <= 1'b1;
              rx_ovf  <= rx_val && !rx_rdy;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else if (sclk_fall && bit_cnt != '0) begin
            tx_shift <= tx_shift << 1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign spi_miso_o = tx_shift[DATA_W-1];
  assign tx_rdy     = ~hold_full;

endmodule

// File: tb/tb_sl_spi_slave.sv
// Bench for sl_spi_slave: bit-banged mode-0 master, scoreboard queues for RX words and MISO bytes.
module tb_sl_spi_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_ss_i = 1'b1;
  logic       spi_sclk_i = 1'b0;
  logic       spi_mosi_i = 1'b0;
  logic       spi_miso_o;
  logic       spi_miso_en;
  logic [7:0] tx_data = 8'h00;
  logic       tx_val = 1'b0;
  logic       tx_rdy;
  logic       tx_undr;
  logic [7:0] rx_data;
  logic       rx_val;
  logic       rx_rdy = 1'b0;
  logic       rx_ovf;
  logic       busy;

  sl_spi_slave #(.DATA_W(8), .SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .rst(rst),
    .spi_ss_i(spi_ss_i), .spi_sclk_i(spi_sclk_i), .spi_mosi_i(spi_mosi_i),
    .spi_miso_o(spi_miso_o), .spi_miso_en(spi_miso_en),
    .tx_data(tx_data), .tx_val(tx_val), .tx_rdy(tx_rdy), .tx_undr(tx_undr),
    .rx_data(rx_data), .rx_val(rx_val), .rx_rdy(rx_rdy), .rx_ovf(rx_ovf),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int undr_cnt = 0;
  int ovf_cnt = 0;
  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_miso_q[$];
  logic [7:0] m_out[4];
  logic [7:0] m_in[4];

  typedef struct {
    logic       has_tx;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
    int         exp_undr;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Handshakes complete on the posedge following this sample point.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (tx_undr) undr_cnt++;
      if (rx_ovf) ovf_cnt++;
      if (rx_val && rx_rdy) begin
        if (exp_rx_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rx_unexpected: got %0h expected no word", rx_data);
        end else begin
          check("rx_word", rx_data, exp_rx_q.pop_front());
        end
      end
    end
  end

  task automatic load_tx(input logic [7:0] b);
    @(negedge clk);
    check("tx_rdy_before_load", tx_rdy, 1);
    tx_data = b;
    tx_val  = 1'b1;
    @(negedge clk);
    tx_val  = 1'b0;
    check("tx_rdy_after_load", tx_rdy, 0);
  endtask

  // SCLK period 8 clk; SS may rise together with the final falling edge.
  task automatic spi_frame(input int nbits, input bit raise_ss);
    @(negedge clk);
    spi_ss_i = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi_i = m_out[i/8][7-(i%8)];
      repeat (4) @(negedge clk);
      m_in[i/8][7-(i%8)] = spi_miso_o;
      spi_sclk_i = 1'b1;
      repeat (4) @(negedge clk);
      spi_sclk_i = 1'b0;
      if (i == nbits - 1 && raise_ss) spi_ss_i = 1'b1;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic check_miso(input int nbytes);
    for (int b = 0; b < nbytes; b++) begin
      if (exp_miso_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL miso_queue: got %0h expected no byte", m_in[b]);
      end else begin
        check("miso_byte", m_in[b], exp_miso_q.pop_front());
      end
    end
  endtask

  task automatic drain();
    rx_rdy = 1'b1;
    for (int k = 0; k < 50 && exp_rx_q.size() != 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("rx_drain_remaining", exp_rx_q.size(), 0);
  endtask

  initial begin
    int u0, o0;
    vecs[0] = '{1'b1, 8'hA5, 8'hC3, 8'hA5, 8'hC3, 0};
    vecs[1] = '{1'b0, 8'h00, 8'h5A, 8'hFF, 8'h5A, 1};
    vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 0};
    vecs[3] = '{1'b1, 8'h80, 8'h01, 8'h80, 8'h01, 0};
    vecs[4] = '{1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 1};

    repeat (3) @(negedge clk);
    check("rst_miso", spi_miso_o, 0);
    check("rst_miso_en", spi_miso_en, 0);
    check("rst_tx_rdy", tx_rdy, 1);
    check("rst_rx_val", rx_val, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single byte, rx_val held until accepted
    rx_rdy = 1'b0;
    load_tx(8'hA5);
    exp_miso_q.push_back(8'hA5);
    m_out[0] = 8'h3C;
    spi_frame(8, 1);
    check_miso(1);
    check("single_tx_rdy", tx_rdy, 1);
    check("single_rx_val", rx_val, 1);
    check("single_rx_data", rx_data, 8'h3C);
    repeat (10) @(negedge clk);
    check("single_rx_val_held", rx_val, 1);
    exp_rx_q.push_back(8'h3C);
    drain();
    check("single_rx_val_clr", rx_val, 0);

    foreach (vecs[v]) begin
      rx_rdy = 1'b1;
      u0 = undr_cnt;
      if (vecs[v].has_tx) load_tx(vecs[v].tx);
      exp_miso_q.push_back(vecs[v].exp_miso);
      exp_rx_q.push_back(vecs[v].exp_rx);
      m_out[0] = vecs[v].mosi;
      spi_frame(8, 1);
      check_miso(1);
      drain();
      check("vec_undr", undr_cnt - u0, vecs[v].exp_undr);
    end

    // Burst of three words, second TX byte written mid-frame
    rx_rdy = 1'b1;
    load_tx(8'h01);
    exp_miso_q.push_back(8'h01);
    exp_miso_q.push_back(8'h02);
    exp_miso_q.push_back(8'hFF);
    exp_rx_q.push_back(8'h11);
    exp_rx_q.push_back(8'h22);
    exp_rx_q.push_back(8'h33);
    m_out[0] = 8'h11; m_out[1] = 8'h22; m_out[2] = 8'h33;
    u0 = undr_cnt;
    fork
      spi_frame(24, 1);
      begin
        repeat (20) @(negedge clk);
        load_tx(8'h02);
      end
    join
    check_miso(3);
    drain();
    check("burst_undr", undr_cnt - u0, 1);

    // Overflow
    rx_rdy = 1'b0;
    exp_miso_q.push_back(8'hFF);
    exp_miso_q.push_back(8'hFF);
    m_out[0] = 8'hAA; m_out[1] = 8'h55;
    o0 = ovf_cnt;
    spi_frame(16, 1);
    check_miso(2);
    check("ovf_pulses", ovf_cnt - o0, 1);
    check("ovf_rx_val", rx_val, 1);
    check("ovf_rx_data", rx_data, 8'h55);
    exp_rx_q.push_back(8'h55);
    drain();

    // Abort after 5 bits, then a full frame
    rx_rdy = 1'b1;
    m_out[0] = 8'hF0;
    spi_frame(5, 1);
    check("abort_rx_val", rx_val, 0);
    check("abort_rx_data", rx_data, 8'h55);
    check("abort_busy", busy, 0);
    check("abort_miso_en", spi_miso_en, 0);
    exp_miso_q.push_back(8'hFF);
    exp_rx_q.push_back(8'h81);
    m_out[0] = 8'h81;
    spi_frame(8, 1);
    check_miso(1);
    drain();

    // Reset mid-frame, with a TX byte pending in the holding register
    m_out[0] = 8'hFF;
    spi_frame(3, 0);
    check("mid_busy", busy, 1);
    check("mid_miso_en", spi_miso_en, 1);
    check("mid_miso", spi_miso_o, 1);
    load_tx(8'h77);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_miso_en", spi_miso_en, 0);
    check("arst_busy", busy, 0);
    check("arst_miso", spi_miso_o, 0);
    check("arst_tx_rdy", tx_rdy, 1);
    check("arst_rx_data", rx_data, 0);
    check("arst_rx_val", rx_val, 0);
    spi_ss_i = 1'b1;
    spi_sclk_i = 1'b0;
    spi_mosi_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    exp_miso_q.push_back(8'hFF);
    exp_rx_q.push_back(8'h5A);
    m_out[0] = 8'h5A;
    spi_frame(8, 1);
    check_miso(1);
    drain();
    check("post_rst_rx_data", rx_data, 8'h5A);
    check("miso_queue_left", exp_miso_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
